game_state_ctrl: RTL and testbench

Top-level Pac-Man game sequencer: owns the game state machine, lives, the post-death resume delay and ghost/pacman collision arbitration. It sits beside the sprite location controllers, map RAM writer and pill counter and drives their resets and enables. Generalises the original fixed two-ghost controller:
- ghost count, lives, win threshold and resume delay are parameters.
- collisions are edge-qualified.
- eaten-ghost pulses are generated.
- terminal states can restart without a hard reset.

---
 rtl/game_state_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_state_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Pac-Man game sequencer: state machine, lives, resume delay and collision arbitration.
// Optional GAME_PAUSE_EN enables the pause input and the PAUSED state.
module game_state_ctrl #(
  parameter int unsigned NUM_GHOSTS   = 2,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned WIN_DOTS     = 309,
  parameter int unsigned RESUME_DELAY = 250000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic [5:0]              pacman_x,
  input  logic [4:0]              pacman_y,
  input  logic [6*NUM_GHOSTS-1:0] ghost_x,
  input  logic [5*NUM_GHOSTS-1:0] ghost_y,
  input  logic                    power_active,
  input  logic [9:0]              dot_count,
  output logic [2:0]              state,
  output logic [2:0]              lives,
  output logic                    sprite_reset,
  output logic                    map_wr_reset,
  output logic                    dot_counter_reset,
  output logic                    ghost_enable,
  output logic                    freeze,
  output logic [NUM_GHOSTS-1:0]   ghost_eaten,
  output logic                    death
);

  localparam int unsigned CW = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(RESUME_DELAY - 1);
  localparam logic [2:0]    LIVES_LOAD = 3'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_PLAY   = 3'd1,
    S_RESUME = 3'd2,
    S_OVER   = 3'd3,
    S_WIN    = 3'd4,
    S_PAUSED = 3'd5
  } state_t;

  state_t                state_q, state_n;
  logic [2:0]            lives_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [NUM_GHOSTS-1:0] col, hit, eat, hit_prev, eat_prev, eat_evt;
  logic                  death_evt, start_prev, start_rise, win;
  logic [4:0]            outs_n;  // {sprite_reset, map_wr_reset, dot_counter_reset, ghost_enable, freeze}

`ifdef GAME_PAUSE_EN
  logic pause_prev, pause_rise;
  assign pause_rise = pause & ~pause_prev;
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  assign state      = state_q;
  assign start_rise = start & ~start_prev;
  assign win        = 32'(dot_count) >= WIN_DOTS;

  always_comb begin
    col = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      col[i] = (ghost_x[6*i +: 6] == pacman_x) && (ghost_y[5*i +: 5] == pacman_y);
    end
    hit       = col & {NUM_GHOSTS{~power_active}};
    eat       = col & {NUM_GHOSTS{power_active}};
    death_evt = (state_q == S_PLAY) && (|(hit & ~hit_prev));
    eat_evt   = (state_q == S_PLAY) ? (eat & ~eat_prev) : '0;
  end

  always_comb begin
    state_n = state_q;
    lives_n = lives;
    cnt_n   = cnt_q;
    case (state_q)
      S_INIT: begin
        lives_n = LIVES_LOAD;
        if (start) state_n = S_PLAY;
      end
      S_PLAY: begin
        if (death_evt) begin
          if (lives > 3'd1) begin
            state_n = S_RESUME;
            lives_n = lives - 3'd1;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = S_OVER;
            lives_n = '0;
          end
        end else if (win) begin
          state_n = S_WIN;
        end
`ifdef GAME_PAUSE_EN
        else if (pause_rise) begin
          state_n = S_PAUSED;
        end
`endif
      end
      S_RESUME: begin
        if (cnt_q == '0) state_n = S_PLAY;
        else             cnt_n   = cnt_q - 1'b1;
      end
`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (pause_rise) state_n = S_PLAY;
      end
`endif
      S_OVER, S_WIN: begin
        if (start_rise) begin
          state_n = S_INIT;
          lives_n = LIVES_LOAD;
        end
      end
      default: state_n = S_INIT;
    endcase

    // Outputs decoded from the next state so they register in step with state.
    outs_n = 5'b11101;
    case (state_n)
      S_PLAY:   outs_n = 5'b00010;
      S_RESUME: outs_n = 5'b10001;
      S_OVER:   outs_n = 5'b01001;
      S_WIN:    outs_n = 5'b00001;
      S_PAUSED: outs_n = 5'b00001;
      default:  outs_n = 5'b11101;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q           <= S_INIT;
      lives             <= LIVES_LOAD;
      cnt_q             <= '0;
      hit_prev          <= '0;
      eat_prev          <= '0;
      start_prev        <= 1'b0;
      sprite_reset      <= 1'b1;
      map_wr_reset      <= 1'b1;
      dot_counter_reset <= 1'b1;
      ghost_enable      <= 1'b0;
      freeze            <= 1'b1;
      ghost_eaten       <= '0;
      death             <= 1'b0;
    end else begin
      state_q    <= state_n;
      lives      <= lives_n;
      cnt_q      <= cnt_n;
      start_prev <= start;
      // Edge history keeps tracking through RESUME so a collision held across
      // the resume delay is not counted as a fresh death.
      if (state_q == S_PLAY || state_q == S_RESUME) begin
        hit_prev <= hit;
        eat_prev <= eat;
      end else begin
        hit_prev <= '0;
        eat_prev <= '0;
      end
      {sprite_reset, map_wr_reset, dot_counter_reset, ghost_enable, freeze} <= outs_n;
      ghost_eaten <= death_evt ? '0 : eat_evt;
      death       <= death_evt;
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) pause_prev <= 1'b0;
    else       pause_prev <= pause;
  end
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: per-cycle expectations are queued with
// the stimulus and compared one clock later.
module tb_game_state_ctrl;

  localparam int unsigned NG = 3;

  logic          clk = 1'b0;
  logic          reset, start, pause, power_active;
  logic [5:0]    pacman_x;
  logic [4:0]    pacman_y;
  logic [6*NG-1:0] ghost_x;
  logic [5*NG-1:0] ghost_y;
  logic [9:0]    dot_count;
  logic [2:0]    state, lives;
  logic          sprite_reset, map_wr_reset, dot_counter_reset, ghost_enable, freeze, death;
  logic [NG-1:0] ghost_eaten;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [2:0] lv;
    logic       dth;
    logic [2:0] ea;
  } exp_t;

  exp_t exp_q[$];

  game_state_ctrl #(
    .NUM_GHOSTS(NG), .LIVES_INIT(3), .WIN_DOTS(5), .RESUME_DELAY(8)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .pause(pause),
    .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .power_active(power_active), .dot_count(dot_count),
    .state(state), .lives(lives), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
    .dot_counter_reset(dot_counter_reset), .ghost_enable(ghost_enable), .freeze(freeze),
    .ghost_eaten(ghost_eaten), .death(death)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected {sprite_reset, map_wr_reset, dot_counter_reset, ghost_enable, freeze}
  // and a mask of the bits defined for that state.
  function automatic logic [9:0] outs_for(input logic [2:0] st);
    case (st)
      3'd0:    return {5'b11101, 5'b11111};
      3'd1:    return {5'b00010, 5'b11111};
      3'd2:    return {5'b10001, 5'b11111};
      3'd3:    return {5'b01001, 5'b01011};
      3'd4:    return {5'b00001, 5'b00011};
      default: return {5'b00001, 5'b11111};
    endcase
  endfunction

  task automatic cyc(input string tag, input logic [2:0] st, input logic [2:0] lv,
                     input logic dth, input logic [2:0] ea);
    exp_t e;
    logic [9:0] om;
    logic [4:0] obs;
    exp_q.push_back('{tag, st, lv, dth, ea});
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    om = outs_for(e.st);
    obs = {sprite_reset, map_wr_reset, dot_counter_reset, ghost_enable, freeze};
    check({e.tag, ".state"}, state, e.st);
    check({e.tag, ".lives"}, lives, e.lv);
    check({e.tag, ".death"}, death, e.dth);
    check({e.tag, ".eaten"}, ghost_eaten, e.ea);
    check({e.tag, ".ctl"}, obs & om[4:0], om[9:5] & om[4:0]);
  endtask

  task automatic place(input int unsigned i, input bit on);
    ghost_x[6*i +: 6] = on ? 6'd10 : 6'(40 + i);
    ghost_y[5*i +: 5] = on ? 5'd10 : 5'd2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; power_active = 1'b0; dot_count = '0;
    pacman_x = 6'd10; pacman_y = 5'd10;
    ghost_x = '0; ghost_y = '0;
    for (int unsigned i = 0; i < NG; i++) place(i, 1'b0);

    cyc("rst0", 0, 3, 0, 0);
    cyc("rst1", 0, 3, 0, 0);
    reset = 1'b0;
    cyc("idle", 0, 3, 0, 0);
    start = 1'b1;
    cyc("start", 1, 3, 0, 0);
    start = 1'b0;
    cyc("play", 1, 3, 0, 0);

    // Collision held 20 cycles: one death, exactly 8 cycles of RESUME.
    place(2, 1'b1);
    cyc("hit_a", 2, 2, 1, 0);
    for (int i = 0; i < 7; i++) cyc("res_a", 2, 2, 0, 0);
    for (int i = 0; i < 12; i++) cyc("held", 1, 2, 0, 0);
    place(2, 1'b0);
    cyc("rel_a", 1, 2, 0, 0);

    place(0, 1'b1);
    cyc("hit_b", 2, 1, 1, 0);
    place(0, 1'b0);
    for (int i = 0; i < 7; i++) cyc("res_b", 2, 1, 0, 0);
    cyc("back_b", 1, 1, 0, 0);
    place(1, 1'b1);
    cyc("hit_c", 3, 0, 1, 0);
    place(1, 1'b0);
    cyc("over", 3, 0, 0, 0);
    start = 1'b1;
    cyc("restart", 0, 3, 0, 0);
    cyc("replay", 1, 3, 0, 0);
    start = 1'b0;

    // Two ghosts eaten in the same cycle.
    power_active = 1'b1;
    place(0, 1'b1); place(1, 1'b1);
    cyc("eat", 1, 3, 0, 3'b011);
    cyc("eat_hold", 1, 3, 0, 0);
    place(0, 1'b0); place(1, 1'b0); power_active = 1'b0;
    cyc("eat_rel", 1, 3, 0, 0);

    // Win threshold boundary and death priority over win.
    dot_count = 10'd4;
    cyc("dot4", 1, 3, 0, 0);
    cyc("dot4b", 1, 3, 0, 0);
    dot_count = 10'd5;
    place(2, 1'b1);
    cyc("dot_death", 2, 2, 1, 0);
    place(2, 1'b0);
    for (int i = 0; i < 7; i++) cyc("res_d", 2, 2, 0, 0);
    cyc("back_d", 1, 2, 0, 0);
    cyc("win", 4, 2, 0, 0);
    cyc("win_hold", 4, 2, 0, 0);
    dot_count = '0;
    start = 1'b1;
    cyc("win_restart", 0, 3, 0, 0);
    start = 1'b0;
    cyc("init_hold", 0, 3, 0, 0);
    start = 1'b1;
    cyc("go", 1, 3, 0, 0);
    start = 1'b0;

    pause = 1'b1;
`ifdef GAME_PAUSE_EN
    cyc("pause", 5, 3, 0, 0);
    place(0, 1'b1);
    cyc("paused_col", 5, 3, 0, 0);
    pause = 1'b0;
    cyc("paused_hold", 5, 3, 0, 0);
    place(0, 1'b0);
    pause = 1'b1;
    cyc("unpause", 1, 3, 0, 0);
    pause = 1'b0;
    cyc("unpaused", 1, 3, 0, 0);
`else
    cyc("nopause", 1, 3, 0, 0);
    pause = 1'b0;
    cyc("nopause_rel", 1, 3, 0, 0);
    pause = 1'b1;
    cyc("nopause2", 1, 3, 0, 0);
    pause = 1'b0;
`endif

    // Reset in the middle of RESUME.
    place(2, 1'b1);
    cyc("hit_e", 2, 2, 1, 0);
    place(2, 1'b0);
    cyc("res_e", 2, 2, 0, 0);
    reset = 1'b1;
    cyc("rst_mid", 0, 3, 0, 0);
    reset = 1'b0;
    cyc("after_rst", 0, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
